// File: rtl/shift_reg_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_unit
// Brief    : Bidirectional shift register with parallel load, shift counter
//            and a one-cycle completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module shift_reg_unit #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       sin_r,
    input  logic                       sin_l,
    input  logic [WIDTH-1:0]           pdata,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qb,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] C_MODE_HOLD = 2'b00;
    localparam logic [1:0] C_MODE_SHR  = 2'b01;
    localparam logic [1:0] C_MODE_SHL  = 2'b10;
    localparam logic [1:0] C_MODE_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift_w;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shift_w = 1'b0;

        if (en) begin
            case (mode)
                C_MODE_SHR: begin
                    shreg_d = {sin_r, shreg_q[WIDTH-1:1]};
                    shift_w = 1'b1;
                end
                C_MODE_SHL: begin
                    shreg_d = {shreg_q[WIDTH-2:0], sin_l};
                    shift_w = 1'b1;
                end
                C_MODE_LOAD: begin
                    shreg_d = pdata;
                    cnt_d   = '0;
                end
                C_MODE_HOLD: ;
                default: ;
            endcase
        end

        // Count saturates at WIDTH, so done can only fire on the crossing edge.
        if (shift_w && (cnt_q != C_CNT_MAX)) begin
            cnt_d  = cnt_q + 1'b1;
            done_d = (cnt_q == C_CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign q         = shreg_q;
    assign qb        = ~shreg_q;
    assign sout_r    = shreg_q[0];
    assign sout_l    = shreg_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_reg_unit
// Brief    : Directed self-checking bench for shift_reg_unit (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_shift_reg_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pdata;
    logic [7:0] q;
    logic [7:0] qb;
    logic       sout_r;
    logic       sout_l;
    logic [3:0] shift_cnt;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    shift_reg_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
        .pdata     (pdata),
        .q         (q),
        .qb        (qb),
        .sout_r    (sout_r),
        .sout_l    (sout_l),
        .shift_cnt (shift_cnt),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Inputs change 1ns after each rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic sr,
                         input logic sl, input logic [7:0] pd);
        en    = e;
        mode  = m;
        sin_r = sr;
        sin_l = sl;
        pdata = pd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 2'b11, 1'b1, 1'b1, 8'hFF);
        tick();
        tick();
        n_cmp++;
        if (q !== 8'h00) begin n_err++; $display("FAIL reset_held_q: got %h want 00", q); end
        n_cmp++;
        if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL reset_held_cnt: got %0d want 0", shift_cnt); end
        #4 rst = 1'b0;
        #1;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A);
        tick();
        n_cmp++;
        if (q !== 8'h5A) begin n_err++; $display("FAIL first_load: got %h want 5a", q); end
        drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++;
        if (shift_cnt !== 4'd1) begin n_err++; $display("FAIL pre_reset_cnt: got %0d want 1", shift_cnt); end
        // Assert reset between edges and look before the next edge arrives.
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (q !== 8'h00) begin n_err++; $display("FAIL async_reset_q: got %h want 00", q); end
        n_cmp++;
        if (qb !== 8'hFF) begin n_err++; $display("FAIL async_reset_qb: got %h want ff", qb); end
        n_cmp++;
        if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL async_reset_cnt: got %0d want 0", shift_cnt); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL async_reset_done: got %b want 0", done); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_q [8];
        logic [7:0] exp_sout;
        exp_q    = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        exp_sout = 8'b1010_0101;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5);
        tick();
        n_cmp++;
        if (q !== 8'hA5 || qb !== 8'h5A) begin n_err++; $display("FAIL shr_load: got q=%h qb=%h want a5/5a", q, qb); end
        drive(1'b1, 2'b01, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (sout_r !== exp_sout[7-i]) begin n_err++; $display("FAIL shr_sout_r[%0d]: got %b want %b", i, sout_r, exp_sout[7-i]); end
            tick();
            n_cmp++;
            if (q !== exp_q[i]) begin n_err++; $display("FAIL shr_q[%0d]: got %h want %h", i, q, exp_q[i]); end
            n_cmp++;
            if (shift_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL shr_cnt[%0d]: got %0d want %0d", i, shift_cnt, i + 1); end
            n_cmp++;
            if (done !== (i == 7)) begin n_err++; $display("FAIL shr_done[%0d]: got %b want %b", i, done, (i == 7)); end
        end
        drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL shr_done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_shift_left_fill();
        logic [7:0] exp;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h00);
        tick();
        drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        exp = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {exp[6:0], 1'b1};
            n_cmp++;
            if (q !== exp) begin n_err++; $display("FAIL shl_q[%0d]: got %h want %h", i, q, exp); end
        end
        n_cmp++;
        if (shift_cnt !== 4'd8 || done !== 1'b1) begin n_err++; $display("FAIL shl_8th: got cnt=%0d done=%b want 8/1", shift_cnt, done); end
        n_cmp++;
        if (sout_l !== 1'b1 || qb !== 8'h00) begin n_err++; $display("FAIL shl_outs: got sout_l=%b qb=%h want 1/00", sout_l, qb); end
        tick();
        n_cmp++;
        if (q !== 8'hFF || shift_cnt !== 4'd8 || done !== 1'b0) begin
            n_err++; $display("FAIL shl_9th: got q=%h cnt=%0d done=%b want ff/8/0", q, shift_cnt, done);
        end
        drive(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++;
        if (q !== 8'hFE || shift_cnt !== 4'd8 || done !== 1'b0) begin
            n_err++; $display("FAIL shl_10th: got q=%h cnt=%0d done=%b want fe/8/0", q, shift_cnt, done);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C);
        tick();
        drive(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (q !== 8'h3C || shift_cnt !== 4'd0) begin
                n_err++; $display("FAIL hold_en0[%0d]: got q=%h cnt=%0d want 3c/0", i, q, shift_cnt);
            end
        end
        drive(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF);
        tick();
        n_cmp++;
        if (q !== 8'h3C) begin n_err++; $display("FAIL hold_en0_load: got %h want 3c", q); end
        drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF);
        tick();
        n_cmp++;
        if (q !== 8'h79 || shift_cnt !== 4'd1) begin
            n_err++; $display("FAIL hold_mode00: got q=%h cnt=%0d want 79/1", q, shift_cnt);
        end
    endtask

    task automatic test_load_priority();
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h0F);
        tick();
        // 4 right (0F->00) then 3 left with sin_l=1 (00->07): net 1 right, count 7.
        drive(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        repeat (4) tick();
        drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        repeat (3) tick();
        n_cmp++;
        if (q !== 8'h07 || shift_cnt !== 4'd7 || done !== 1'b0) begin
            n_err++; $display("FAIL mixed_shifts: got q=%h cnt=%0d done=%b want 07/7/0", q, shift_cnt, done);
        end
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
        tick();
        n_cmp++;
        if (q !== 8'h81 || shift_cnt !== 4'd0 || done !== 1'b0) begin
            n_err++; $display("FAIL load_priority: got q=%h cnt=%0d done=%b want 81/0/0", q, shift_cnt, done);
        end
        drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
        tick();
        n_cmp++;
        if (done !== 1'b0 || shift_cnt !== 4'd0) begin
            n_err++; $display("FAIL load_priority_after: got cnt=%0d done=%b want 0/0", shift_cnt, done);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 2'b11, 1'b0, 1'b0, 8'hC3);
        tick();
        drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
        repeat (4) tick();
        n_cmp++;
        if (q !== 8'hFC || shift_cnt !== 4'd4) begin
            n_err++; $display("FAIL mid_pre: got q=%h cnt=%0d want fc/4", q, shift_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (q !== 8'h00 || shift_cnt !== 4'd0) begin
            n_err++; $display("FAIL mid_async_reset: got q=%h cnt=%0d want 00/0", q, shift_cnt);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if (shift_cnt !== 4'(i + 1) || done !== (i == 7)) begin
                n_err++; $display("FAIL mid_post[%0d]: got cnt=%0d done=%b want %0d/%b", i, shift_cnt, done, i + 1, (i == 7));
            end
        end
        n_cmp++;
        if (q !== 8'hFF) begin n_err++; $display("FAIL mid_post_q: got %h want ff", q); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        test_reset();
        test_shift_right();
        test_shift_left_fill();
        test_hold();
        test_load_priority();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_reg_unit.md
SHIFT_REG_UNIT -- requirements
Module: shift_reg_unit

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 8, giving the register width in bits; legal range is 2..32.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port en, input, 1 bit: operation enable; when 0 the block holds all state.
REQ-005 The block SHALL have the port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 The block SHALL have the port sin_r, input, 1 bit: serial input entering q[WIDTH-1] on a shift right.
REQ-007 The block SHALL have the port sin_l, input, 1 bit: serial input entering q[0] on a shift left.
REQ-008 The block SHALL have the port pdata, input, WIDTH bits: parallel load data.
REQ-009 The block SHALL have the port q, output, WIDTH bits: registered contents.
REQ-010 The block SHALL have the port qb, output, WIDTH bits: bitwise complement of q (combinational).
REQ-011 The block SHALL have the port sout_r, output, 1 bit: equal to q[0] (the bit leaving on a shift right).
REQ-012 The block SHALL have the port sout_l, output, 1 bit: equal to q[WIDTH-1] (the bit leaving on a shift left).
REQ-013 The block SHALL have the port shift_cnt, output, clog2(WIDTH+1) bits: number of shifts since the last load or reset.
REQ-014 The block SHALL have the port done, output, 1 bit: a one-cycle registered pulse when shift_cnt reaches WIDTH.

Function
REQ-015 With en=1 and mode=01, q SHALL become {sin_r, q[WIDTH-1:1]} on the clock edge.
REQ-016 With en=1 and mode=10, q SHALL become {q[WIDTH-2:0], sin_l} on the clock edge.
REQ-017 With en=1 and mode=11, q SHALL become pdata and shift_cnt SHALL become 0 on the clock edge.
REQ-018 With en=1 and mode=00, or with en=0, q and shift_cnt SHALL hold their values.
REQ-019 Each enabled shift (mode 01 or 10) SHALL increment shift_cnt by 1, saturating at WIDTH.
REQ-020 done SHALL be 1 in exactly the cycle after the edge on which shift_cnt transitions from WIDTH-1 to WIDTH, and 0 otherwise.
REQ-021 Further shifts while shift_cnt=WIDTH SHALL still move data, SHALL keep shift_cnt at WIDTH, and SHALL NOT re-assert done.
REQ-022 A load on the same edge as an otherwise-completing shift count SHALL take priority: shift_cnt becomes 0 and done stays 0.
REQ-023 Mixed directions SHALL each count as one shift; shift_cnt tracks total shifts and not net displacement.
REQ-024 Latency from a control or data input to q SHALL be one clock edge; qb, sout_r and sout_l SHALL follow q with no additional latency.
REQ-025 The outputs SHALL never carry X or Z after reset, provided the inputs are known.

Reset
REQ-026 Asserting rst SHALL immediately, without waiting for a clock edge, force q=0, shift_cnt=0 and done=0, which makes qb all ones.
REQ-027 While rst=1, all inputs SHALL be ignored; reset asserted in the middle of a shift sequence SHALL discard the partial count.
REQ-028 After rst deasserts, the first operation SHALL take effect on the first rising edge of clk at which rst=0.

Verification
REQ-029 Reset scenario: with WIDTH=8, assert rst between edges -> q=00h, qb=FFh, shift_cnt=0 and done=0 immediately, before the next edge.
REQ-030 Load then shift right: load A5h, then 8 shifts right with sin_r=0 -> q goes 52h, 29h, ..., 00h; done=1 for exactly one cycle after the 8th shift; sout_r sequence is 1,0,1,0,0,1,0,1.
REQ-031 Shift left fill: starting from q=00h, 8 shifts left with sin_l=1 -> q=FFh, shift_cnt=8; a 9th shift -> q=FFh, shift_cnt=8, no done pulse.
REQ-032 Enable and hold: load 3Ch, then hold with en=0 and mode=01 for 5 cycles -> q stays 3Ch and shift_cnt stays 0.
REQ-033 Load priority: after 7 shifts, apply mode=11 with pdata=81h -> q=81h, shift_cnt=0, done=0.
REQ-034 Mid-operation reset: after 4 shifts, assert rst asynchronously -> q=00h and shift_cnt=0 at once; after release, 8 further shifts produce done.
